// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: ADXL345-style SPI mode-3 register slave; define GSENSOR_RESPONDER_INT_EN to add the int1 data-ready interrupt
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_csn,
    input  logic        spi_sclk,
    input  logic        spi_sdi,
    output logic        spi_sdo,
    output logic        spi_sdo_oe,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format,
    output logic        busy,
    output logic        int1
);
    typedef enum logic [1:0] {IDLE, CMD, DATA_RD, DATA_WR} state_t;
    state_t state, state_n;
    logic [1:0] cs_s, sclk_s, sdi_s, age;
    logic cs_d, sclk_d, armed, mb, sdo_q, pend;
    logic [2:0] bit_cnt;
    logic [7:0] shift, bw_rate, int_enable, rd_data, in_byte;
    logic [5:0] addr, rd_addr, next_addr;
    logic [15:0] dx, dy, dz, px, py, pz;
    logic cs, sclk_rise, sclk_fall, cs_fall, active, ending, byte_done;
    assign cs = cs_s[1];
    assign sclk_rise = sclk_s[1] & ~sclk_d;
    assign sclk_fall = ~sclk_s[1] & sclk_d;
    assign cs_fall = armed & cs_d & ~cs;
    assign active = state != IDLE;
    assign ending = active & cs;
    assign byte_done = sclk_rise & (bit_cnt == 3'd7) & ~cs;
    assign in_byte = {shift[6:0], sdi_s[1]};
    assign next_addr = mb ? addr + 6'd1 : addr;
    assign rd_addr = state == CMD ? in_byte[5:0] : next_addr;
    assign busy = ~cs;
    assign spi_sdo_oe = (state == DATA_RD) & ~cs;
    assign spi_sdo = spi_sdo_oe ? sdo_q : 1'b1;
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            6'h00: rd_data = DEVID_VAL;
            6'h2C: rd_data = bw_rate;
            6'h2D: rd_data = power_ctl;
            6'h2E: rd_data = int_enable;
            6'h31: rd_data = data_format;
            6'h32: rd_data = dx[7:0];
            6'h33: rd_data = dx[15:8];
            6'h34: rd_data = dy[7:0];
            6'h35: rd_data = dy[15:8];
            6'h36: rd_data = dz[7:0];
            6'h37: rd_data = dz[15:8];
            default: rd_data = 8'h00;
        endcase
    end
    always_comb begin
        state_n = state;
        if (cs) state_n = IDLE;
        else if (state == IDLE && cs_fall) state_n = CMD;
        else if (state == CMD && byte_done) state_n = in_byte[7] ? DATA_RD : DATA_WR;
    end
    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_s <= 2'b11;
            sclk_s <= 2'b11;
            sdi_s <= 2'b00;
            cs_d <= 1'b1;
            sclk_d <= 1'b1;
            age <= 2'b00;
            armed <= 1'b0;
            bit_cnt <= 3'd0;
            shift <= 8'h00;
            addr <= 6'd0;
            mb <= 1'b0;
            sdo_q <= 1'b1;
            pend <= 1'b0;
            bw_rate <= BW_RATE_RST;
            power_ctl <= 8'h00;
            int_enable <= 8'h00;
            data_format <= 8'h00;
            {dx, dy, dz} <= '0;
            {px, py, pz} <= '0;
        end else begin
            cs_s <= {cs_s[0], spi_csn};
            sclk_s <= {sclk_s[0], spi_sclk};
            sdi_s <= {sdi_s[0], spi_sdi};
            cs_d <= cs;
            sclk_d <= sclk_s[1];
            // a CS fall only counts once a genuine high has been seen since reset
            age <= {age[0], 1'b1};
            armed <= armed | (age[1] & cs);
            bit_cnt <= state == IDLE ? 3'd0 : (sclk_rise & ~cs) ? bit_cnt + 3'd1 : bit_cnt;
            if (state == CMD) begin
                if (sclk_rise) shift <= (byte_done & in_byte[7]) ? rd_data : in_byte;
                if (byte_done) begin
                    addr <= in_byte[5:0];
                    mb <= in_byte[6];
                    sdo_q <= 1'b1;
                end
            end
            if (state == DATA_RD) begin
                if (sclk_fall) begin
                    sdo_q <= shift[7];
                    shift <= {shift[6:0], 1'b0};
                end
                if (byte_done) begin
                    shift <= rd_data;
                    addr <= next_addr;
                end
            end
            if (state == DATA_WR) begin
                if (sclk_rise) shift <= in_byte;
                if (byte_done) begin
                    addr <= next_addr;
                    case (addr)
                        6'h2C: bw_rate <= in_byte;
                        6'h2D: power_ctl <= in_byte;
                        6'h2E: int_enable <= in_byte;
                        6'h31: data_format <= in_byte;
                        default: ;
                    endcase
                end
            end
            if (sample_valid & (~active | cs)) {dx, dy, dz} <= {sample_x, sample_y, sample_z};
            else if (ending & pend) {dx, dy, dz} <= {px, py, pz};
            if (ending | ~active) pend <= 1'b0;
            if (sample_valid & active & ~cs) begin
                pend <= 1'b1;
                {px, py, pz} <= {sample_x, sample_y, sample_z};
            end
        end
    end
`ifdef GSENSOR_RESPONDER_INT_EN
    logic z1_read, load, load_d;
    assign load = (sample_valid & (~active | cs)) | (ending & pend);
    always_ff @(posedge clk) begin
        if (!rst) begin
            z1_read <= 1'b0;
            load_d <= 1'b0;
            int1 <= 1'b0;
        end else begin
            load_d <= load;
            z1_read <= state == IDLE ? 1'b0 : z1_read | ((state == DATA_RD) & byte_done & (addr == 6'h37));
            if (load_d & int_enable[7] & power_ctl[3]) int1 <= 1'b1;
            else if (ending & z1_read) int1 <= 1'b0;
        end
    end
`else
    assign int1 = 1'b0;
`endif
endmodule

// File: doc/gsensor_spi_responder.md
Name: gsensor_spi_responder

Overview:
- SPI slave that emulates the DE10-Lite's on-board G-sensor register interface (ADXL345-style, SPI mode 3, 4-wire).
- Serves as the far end of the accelerometer SPI master: a synthesizable stand-in for the sensor on boards or benches without one.
- Stores X/Y/Z samples and control registers, and answers single-byte and multi-byte register reads and writes issued by the master.

Parameters:
- DEVID_VAL, 8'hE5, read-only value returned at address 0x00
- BW_RATE_RST, 8'h0A, reset value of register 0x2C

Ports:
- clk  in  1  system clock; must be at least 8x the SCLK frequency
- rst  in  1  synchronous, active-low reset
- spi_csn  in  1  chip select, active low
- spi_sclk  in  1  SPI clock, idles high (CPOL=1, CPHA=1)
- spi_sdi  in  1  master-out data
- spi_sdo  out  1  slave-out data
- spi_sdo_oe  out  1  SDO output enable (tri-state control at the top level)
- sample_x, sample_y, sample_z  in  16 each  new axis sample, two's complement
- sample_valid  in  1  one-cycle strobe; loads sample_x/y/z
- power_ctl  out  8  current value of register 0x2D
- data_format  out  8  current value of register 0x31
- busy  out  1  high while a transaction is active (CS low, synchronized)
- int1  out  1  data-ready interrupt (see Optional Feature)

Behaviour:
- Synchronization: spi_csn, spi_sclk and spi_sdi each pass through a 2-FF synchronizer. Edge detect runs on the synchronized SCLK.
- SDI is sampled on the detected SCLK rise. SDO updates on the detected SCLK fall. Added latency is 3 clk cycles from a pin edge.
- Frame format: first byte, MSB first. bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = address.
- States:
  - IDLE -> CMD on synchronized CS fall; bit counter cleared.
  - CMD -> DATA_RD or DATA_WR after the 8th rising edge, selected by R/W.
  - DATA_RD / DATA_WR loop per byte.
  - Any state -> IDLE on CS rise.
- Read: the byte at the current address is loaded into the shift register after the 8th rising edge. Its bit7 drives SDO on the next falling edge; each following falling edge shifts out the next bit.
- spi_sdo_oe is 1 only in DATA_RD while CS is low. Otherwise it is 0 and spi_sdo = 1.
- Write: the register updates on the cycle after the 8th data bit is sampled. A partial byte aborted by CS rise is discarded.
- Address handling after each complete data byte:
  - MB=1: address increments, wrapping 0x3F -> 0x00.
  - MB=0: address holds, so repeated bytes target the same register.
- Register map:
  - 0x00 = DEVID_VAL (read-only).
  - 0x2C BW_RATE, 0x2D POWER_CTL, 0x2E INT_ENABLE, 0x31 DATA_FORMAT are read/write.
  - 0x32..0x37 = X0, X1, Y0, Y1, Z0, Z1 (low byte first), read-only.
  - Unmapped addresses read 0x00; writes to them and to read-only registers are ignored.
- Coherency:
  - sample_valid with CS high: loads the data registers on the next cycle.
  - sample_valid with CS low: captured into a pending buffer and applied on CS rise. A later strobe during the same transaction overwrites the pending value.
  - sample_valid on the same cycle as the synchronized CS fall: the new sample is applied before the transaction reads it.
- busy equals the inverse of synchronized CS.
- Reset (rst=0 at a clk edge):
  - state IDLE; counters, shift register and pending flag cleared
  - spi_sdo=1, spi_sdo_oe=0, busy=0, int1=0
  - BW_RATE=BW_RATE_RST; POWER_CTL, INT_ENABLE, DATA_FORMAT = 0x00
  - data registers 0x0000
  - Reset asserted mid-transaction aborts it. The slave waits for a fresh CS fall before decoding again.

Optional Feature:
- Macro: GSENSOR_RESPONDER_INT_EN
- Defined:
  - int1 is set one cycle after the data registers load, when INT_ENABLE[7]=1 and POWER_CTL[3]=1.
  - int1 clears when a transaction reads address 0x37 (Z1), at the CS rise that ends it.
  - If a load and a clear coincide, set wins.
- Undefined: int1 is tied 0 and no interrupt logic is generated.

Test Plan:
- Read 0x80 (single-byte, address 0x00) -> SDO returns 0xE5; spi_sdo_oe high only during the data byte.
- Write 0x2D then 0x08, release CS, read 0xAD -> power_ctl=0x08 and read returns 0x08.
- sample_valid with X=0x0123, Y=0xFF00, Z=0x7FFE; multi-byte read 0xF2 for 6 bytes -> 23 01 00 FF FE 7F.
- sample_valid mid-transaction during the read of 0xF2 -> old sample returned intact; the next read returns the new sample.
- Multi-byte read 0xFF for 2 bytes -> 0x00 then 0xE5 (wrap 0x3F->0x00). CS raised after 4 bits of a write to 0x31 -> data_format unchanged.
- Reset asserted mid-write -> all outputs at reset values; next transaction decodes normally. With GSENSOR_RESPONDER_INT_EN: enable INT (0x2E=0x80, 0x2D=0x08), pulse sample_valid -> int1=1; read through 0x37 -> int1=0.
